mem_sram_ctrl: RTL and testbench

- MEM-stage access controller, directly downstream of the EXE-stage ALU.
- Consumes the ALU result (LDR/STR effective address) and the store value, and performs 32-bit word accesses on a 16-bit external SRAM as two half-word transfers.
- Holds ready low while an access is in progress; the hazard/freeze logic uses ready to stall every pipeline register.

---
 rtl/mem_sram_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_sram_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_ctrl.sv
// rtl/mem_sram_ctrl.sv - MEM-stage 32-bit load/store controller over a 16-bit SRAM
// Optional one-entry read cache enabled by defining MEM_READ_CACHE_EN.
module mem_sram_ctrl #(
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 5,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        alu_res,
    input  logic [31:0]        st_val,
    output logic               ready,
    output logic [31:0]        read_data,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in
);
    localparam int                CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0]     LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [SRAM_AW:0]  BASE = (SRAM_AW + 1)'(ADDR_BASE);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_cnt;
    logic [SRAM_AW-2:0]   r_idx;
    logic [31:0]          r_st_val;
    logic                 r_is_wr;
    logic [15:0]          r_lo;
    logic [31:0]          r_read_data;
    logic [SRAM_AW-1:0]   r_sram_addr;

    logic [SRAM_AW:0]     w_off;
    logic [SRAM_AW-2:0]   w_idx;
    logic                 w_req;
    logic                 w_last;
    logic                 w_hit;
    logic                 w_start;
    logic                 w_unused;

    // Only the low SRAM_AW+1 bits of the offset matter; the borrow never flows downward.
    assign w_off    = alu_res[SRAM_AW:0] - BASE;
    assign w_idx    = w_off[SRAM_AW:2];
    assign w_unused = ^{alu_res[31:SRAM_AW+1], w_off[1:0]};
    assign w_req    = mem_r_en | mem_w_en;
    assign w_last   = (r_cnt == LAST);
    assign w_start  = (r_state == S_IDLE) && w_req && !w_hit;

    assign sram_addr = r_sram_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        ready       = 1'b0;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = (r_state == S_HI) ? r_st_val[31:16] : r_st_val[15:0];
        case (r_state)
            S_IDLE: begin
                ready = !w_req || w_hit;
                if (w_start) w_next = S_LO;
            end
            S_LO: begin
                sram_we_n  = !r_is_wr;
                sram_dq_oe = r_is_wr;
                if (w_last) w_next = S_HI;
            end
            S_HI: begin
                sram_we_n  = !r_is_wr;
                sram_dq_oe = r_is_wr;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                ready  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_st_val    <= '0;
            r_is_wr     <= 1'b0;
            r_lo        <= '0;
            r_read_data <= '0;
            r_sram_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt       <= '0;
                        r_idx       <= w_idx;
                        r_st_val    <= st_val;
                        r_is_wr     <= mem_w_en;
                        r_sram_addr <= {w_idx, 1'b0};
                    end
                end
                S_LO: begin
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_sram_addr <= {r_idx, 1'b1};
                        if (!r_is_wr) r_lo <= sram_dq_in;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_HI: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (!r_is_wr) r_read_data <= {sram_dq_in, r_lo};
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_READ_CACHE_EN
    logic               r_c_valid;
    logic [SRAM_AW-2:0] r_c_idx;
    logic [31:0]        r_c_data;

    // The entry is refreshed on the DONE cycle so the very next IDLE request sees it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_valid <= 1'b0;
            r_c_idx   <= '0;
            r_c_data  <= '0;
        end else if (r_state == S_DONE) begin
            if (!r_is_wr) begin
                r_c_valid <= 1'b1;
                r_c_idx   <= r_idx;
                r_c_data  <= r_read_data;
            end else if (r_c_valid && (r_c_idx == r_idx)) begin
                r_c_data <= r_st_val;
            end
        end
    end

    assign w_hit     = (r_state == S_IDLE) && mem_r_en && !mem_w_en && r_c_valid && (r_c_idx == w_idx);
    assign read_data = w_hit ? r_c_data : r_read_data;
`else
    assign w_hit     = 1'b0;
    assign read_data = r_read_data;
`endif

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb/tb_mem_sram_ctrl.sv - self-checking bench for mem_sram_ctrl with SRAM and word-level reference model
module tb_mem_sram_ctrl;

`ifdef MEM_READ_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic        ready;
    logic [31:0] read_data;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;

    mem_sram_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .alu_res    (alu_res),
        .st_val     (st_val),
        .ready      (ready),
        .read_data  (read_data),
        .sram_addr  (sram_addr),
        .sram_we_n  (sram_we_n),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in)
    );

    always #5 clk = ~clk;

    logic [15:0] sram [0:262143];
    assign sram_dq_in = sram[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n) sram[sram_addr] <= sram_dq_out;
    end

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [int];
    logic [17:0] last_addr;
    logic [31:0] last_read;
    bit          c_valid;
    int          c_idx;
    logic [31:0] c_data;

    bit          chk_en = 1'b0;
    logic        exp_ready;
    logic        exp_we_n;
    logic        exp_oe;
    logic [15:0] exp_dq;
    logic [17:0] exp_addr;
    bit          exp_rdchk;
    logic [31:0] exp_rd;
    logic [31:0] got_rd;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(ready), 32'(exp_ready));
            chk("we_n", 32'(sram_we_n), 32'(exp_we_n));
            chk("dq_oe", 32'(sram_dq_oe), 32'(exp_oe));
            chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
            if (exp_oe) chk("dq_out", 32'(sram_dq_out), 32'(exp_dq));
            if (exp_rdchk) chk("read_data", read_data, exp_rd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'((off >> 2) % 32'h20000);
    endfunction

    // One instruction: drive the request, publish per-cycle expectations, update the model on completion.
    task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] v, input int rst_at);
        int          idx;
        logic [31:0] word;
        bit          hit;
        idx  = idx_of(a);
        word = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
        mem_w_en = wr;
        mem_r_en = rd;
        alu_res  = a;
        st_val   = v;
        hit = CACHE && rd && !wr && c_valid && (c_idx == idx);
        exp_we_n  = 1'b1;
        exp_oe    = 1'b0;
        exp_dq    = 16'h0;
        exp_addr  = last_addr;
        exp_rdchk = 1'b0;
        exp_rd    = 32'h0;
        if (!wr && !rd) begin
            exp_ready = 1'b1;
            step();
            return;
        end
        if (hit) begin
            exp_ready = 1'b1;
            exp_rdchk = 1'b1;
            exp_rd    = c_data;
            #1 got_rd = read_data;
            step();
            return;
        end
        for (int n = 0; n <= 11; n++) begin
            exp_ready = (n == 11);
            if (n >= 1 && n <= 10) begin
                exp_addr = 18'(2 * idx + ((n > 5) ? 1 : 0));
                exp_we_n = !wr;
                exp_oe   = wr;
                exp_dq   = (n <= 5) ? v[15:0] : v[31:16];
            end else if (n == 11) begin
                exp_addr = 18'(2 * idx + 1);
                exp_we_n = 1'b1;
                exp_oe   = 1'b0;
                if (rd) begin
                    exp_rdchk = 1'b1;
                    exp_rd    = wr ? last_read : word;
                end
            end
            if (n == rst_at) rst = 1'b1;
            #1 got_rd = read_data;
            step();
            if (n == rst_at) begin
                rst       = 1'b0;
                mem_w_en  = 1'b0;
                mem_r_en  = 1'b0;
                last_addr = 18'h0;
                last_read = 32'h0;
                c_valid   = 1'b0;
                if (wr) ref_mem[idx] = v;
                return;
            end
        end
        if (wr) begin
            ref_mem[idx] = v;
            if (c_valid && c_idx == idx) c_data = v;
        end else begin
            last_read = word;
            c_valid   = 1'b1;
            c_idx     = idx;
            c_data    = word;
        end
        last_addr = 18'(2 * idx + 1);
    endtask

    initial begin
        logic [31:0] wv;
        for (int i = 0; i < 262144; i++) sram[i] = 16'h0;
        rst       = 1'b1;
        mem_r_en  = 1'b0;
        mem_w_en  = 1'b0;
        alu_res   = 32'h0;
        st_val    = 32'h0;
        last_addr = 18'h0;
        last_read = 32'h0;
        c_valid   = 1'b0;
        c_idx     = 0;
        c_data    = 32'h0;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_read_data", read_data, 32'h0);
        chk("reset_addr", 32'(sram_addr), 32'h0);
        chk_en = 1'b1;

        repeat (5) access(1'b0, 1'b0, 32'h0, 32'h0, -1);

        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, -1);
        chk("str_lo_half", 32'(sram[0]), 32'h0000BEEF);
        chk("str_hi_half", 32'(sram[1]), 32'h0000DEAD);

        access(1'b0, 1'b1, 32'd1024, 32'h0, -1);
        chk("ldr_word", got_rd, 32'hDEADBEEF);

        access(1'b1, 1'b1, 32'd1028, 32'h12345678, -1);
        chk("both_lo", 32'(sram[2]), 32'h00005678);
        chk("both_hi", 32'(sram[3]), 32'h00001234);
        chk("both_rd_kept", got_rd, 32'hDEADBEEF);

        access(1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 8);
        repeat (2) access(1'b0, 1'b0, 32'h0, 32'h0, -1);
        access(1'b0, 1'b1, 32'd1024, 32'h0, -1);
        chk("ldr_after_rst", got_rd, 32'hDEADBEEF);

        access(1'b0, 1'b1, 32'd1024, 32'h0, -1);
        chk("ldr_repeat", got_rd, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1024, 32'h0, -1);
        access(1'b0, 1'b1, 32'd1024, 32'h0, -1);
        chk("ldr_after_zero_str", got_rd, 32'h0);

        wv = $urandom;
        access(1'b1, 1'b0, 32'h0, wv, -1);
        access(1'b0, 1'b1, 32'h0, 32'h0, -1);
        chk("wrap_low_addr", got_rd, wv);
        wv = $urandom;
        access(1'b1, 1'b0, 32'd1024 + 32'd524288 + 32'd4, wv, -1);
        access(1'b0, 1'b1, 32'd1029, 32'h0, -1);
        chk("wrap_high_bits", got_rd, wv);

        for (int k = 0; k < 40; k++) begin
            int          op;
            logic [31:0] a;
            op = int'($urandom_range(0, 3));
            a  = 32'd1024 + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
            access(op[1], op[0], a, $urandom, -1);
        end

        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
